// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: controller state encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Used by the slave port, master mux and arbiter so all ends agree on widths and states.
package bus_pkg;

  localparam int ADDR_WIDTH_DEF     = 12;
  localparam int MEM_ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF     = 8;
  localparam int BURST_WIDTH_DEF    = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    WDATA  = 3'd2,
    RFETCH = 3'd3,
    RDATA  = 3'd4
  } state_t;

endpackage

// File: rtl/slave_mem.sv
// Local word memory of a slave: 2**MEM_ADDR_WIDTH words of DATA_WIDTH bits, one write port, one registered read port.
// Latency: write lands on the enabling edge; read data appears one cycle after rd_addr is presented.
// Backpressure: none; always accepts.
// Ports: clk; wr_en/wr_addr/wr_dat write port; rd_addr in, rd_dat out (registered). Contents are not reset.
module slave_mem
  import bus_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [MEM_ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_dat,
  input  logic [MEM_ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_dat
);

  logic [DATA_WIDTH-1:0] mem [2**MEM_ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
    rd_dat_q <= mem[rd_addr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/slave_port.sv
// Responder end of the serial bus: deserialises address/burst/write data, accesses local memory, serialises read data.
// Latency: first read bit is valid one cycle (RFETCH) after the last address bit; tx_done pulses the cycle after the last beat.
// Backpressure: slave_ready drops in RFETCH/RDATA; master_ready=0 holds rx_data/slave_valid stable.
// Ports: clk, rst (sync, active-high); master_valid/master_ready handshakes; read_en/write_en sampled at start;
//        tx_address/tx_data/tx_burst serial in; slave_ready/slave_valid/rx_data/busy/tx_done out (all registered).
module slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int BURST_WIDTH    = BURST_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic master_valid,
  input  logic master_ready,
  input  logic read_en,
  input  logic write_en,
  input  logic tx_address,
  input  logic tx_data,
  input  logic tx_burst,
  output logic slave_ready,
  output logic slave_valid,
  output logic rx_data,
  output logic busy,
  output logic tx_done
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);
  localparam logic [CW-1:0] ADDR_LAST  = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] BURST_BITS = CW'(BURST_WIDTH);

  state_t                  state_q, state_d;
  logic                    is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BURST_WIDTH-1:0]  burst_q, burst_d;
  logic [BURST_WIDTH-1:0]  beat_q, beat_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   sr_q, sr_d;
  logic                    slave_ready_q, slave_ready_d;
  logic                    slave_valid_q, slave_valid_d;
  logic                    rx_data_q, rx_data_d;
  logic                    busy_q, busy_d;
  logic                    tx_done_q, tx_done_d;

  logic                    in_xfer, out_xfer, mem_we;
  logic [DATA_WIDTH-1:0]   mem_rd_dat;

  assign in_xfer  = master_valid & slave_ready_q;
  assign out_xfer = slave_valid_q & master_ready;

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    tx_done_d = 1'b0;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        // Address and burst arrive LSB first and are shifted in from the top,
        // so stale contents are fully flushed by the time the field completes.
        if (in_xfer && (read_en ^ write_en)) begin
          is_wr_d = write_en;
          addr_d  = {tx_address, addr_q[ADDR_WIDTH-1:1]};
          burst_d = {tx_burst, burst_q[BURST_WIDTH-1:1]};
          cnt_d   = CW'(1);
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (in_xfer) begin
          addr_d = {tx_address, addr_q[ADDR_WIDTH-1:1]};
          if (cnt_q < BURST_BITS) begin
            burst_d = {tx_burst, burst_q[BURST_WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            beat_d  = '0;
            state_d = is_wr_q ? WDATA : RFETCH;
          end
        end
      end
      WDATA: begin
        if (in_xfer) begin
          sr_d  = {tx_data, sr_q[DATA_WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DATA_LAST) begin
            mem_we                      = 1'b1;
            cnt_d                       = '0;
            addr_d[MEM_ADDR_WIDTH-1:0]  = addr_q[MEM_ADDR_WIDTH-1:0] + 1'b1;
            beat_d                      = beat_q + 1'b1;
            if (beat_q == burst_q) begin
              state_d   = IDLE;
              tx_done_d = 1'b1;
            end
          end
        end
      end
      RFETCH: begin
        sr_d    = mem_rd_dat;
        state_d = RDATA;
      end
      RDATA: begin
        if (out_xfer) begin
          sr_d  = {1'b0, sr_q[DATA_WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DATA_LAST) begin
            cnt_d                      = '0;
            addr_d[MEM_ADDR_WIDTH-1:0] = addr_q[MEM_ADDR_WIDTH-1:0] + 1'b1;
            beat_d                     = beat_q + 1'b1;
            if (beat_q == burst_q) begin
              state_d   = IDLE;
              tx_done_d = 1'b1;
            end else begin
              state_d = RFETCH;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    slave_ready_d = (state_d == IDLE) || (state_d == ADDR) || (state_d == WDATA);
    slave_valid_d = (state_d == RDATA);
    busy_d        = (state_d != IDLE);
    rx_data_d     = (state_d == RDATA) & sr_d[0];
  end

  // Read port is addressed with the next address so the word is already
  // registered in the memory while the controller sits in RFETCH.
  slave_mem #(
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we & ~rst),
    .wr_addr (addr_q[MEM_ADDR_WIDTH-1:0]),
    .wr_dat  (sr_d),
    .rd_addr (addr_d[MEM_ADDR_WIDTH-1:0]),
    .rd_dat  (mem_rd_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      is_wr_q       <= 1'b0;
      addr_q        <= '0;
      burst_q       <= '0;
      beat_q        <= '0;
      cnt_q         <= '0;
      sr_q          <= '0;
      slave_ready_q <= 1'b0;
      slave_valid_q <= 1'b0;
      rx_data_q     <= 1'b0;
      busy_q        <= 1'b0;
      tx_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_wr_q       <= is_wr_d;
      addr_q        <= addr_d;
      burst_q       <= burst_d;
      beat_q        <= beat_d;
      cnt_q         <= cnt_d;
      sr_q          <= sr_d;
      slave_ready_q <= slave_ready_d;
      slave_valid_q <= slave_valid_d;
      rx_data_q     <= rx_data_d;
      busy_q        <= busy_d;
      tx_done_q     <= tx_done_d;
    end
  end

  assign slave_ready = slave_ready_q;
  assign slave_valid = slave_valid_q;
  assign rx_data     = rx_data_q;
  assign busy        = busy_q;
  assign tx_done     = tx_done_q;

endmodule
